// File: rtl/pkg_rv_decode.sv
// ---------------------------------------------------------------------------
// pkg_rv_decode -- decode-stage types shared with the execute controller.
//   alu_t      : ALU operation selector (RV32IM subset)
//   ex_state_t : execute controller state
//   EX_TIMEOUT : default WAIT/DRAIN cycle limit before abort
// ---------------------------------------------------------------------------
package pkg_rv_decode;

    `include "rv_types.svh"

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR,  ALU_AND, ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_t;

    typedef enum logic [2:0] {
        EX_IDLE, EX_ISSUE, EX_WAIT, EX_DONE, EX_DRAIN
    } ex_state_t;

    localparam int EX_TIMEOUT = 64;

endpackage

// File: rtl/rv_ex_timer.sv
// ---------------------------------------------------------------------------
// rv_ex_timer -- cycle counter bounding time spent in WAIT / DRAIN.
//   clk, xreset : clock, asynchronous active-high reset
//   clr         : restart the count (asserted on the entry edge)
//   en          : controller is in a timed state this cycle
//   term        : this is the TIMEOUT-th timed cycle since the last clear
// ---------------------------------------------------------------------------
module rv_ex_timer
    import pkg_rv_decode::*;
#(
    parameter int TIMEOUT = EX_TIMEOUT
) (
    input  logic clk,
    input  logic xreset,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge xreset) begin
        if (xreset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    // cnt holds the number of timed cycles already completed, so the
    // TIMEOUT-th cycle is the one that sees TIMEOUT-1.
    assign term = en && (cnt == LAST);

endmodule

// File: rtl/rv_types.svh
// ---------------------------------------------------------------------------
// rv_types.svh -- scalar types shared across the RV core.
//   u32_t     : 32-bit machine word
//   reg_idx_t : architectural register index (x0..x31)
// ---------------------------------------------------------------------------
`ifndef RV_TYPES_SVH
`define RV_TYPES_SVH

typedef logic [31:0] u32_t;
typedef logic [4:0]  reg_idx_t;

`endif

// File: rtl/rv_exec_ctl.sv
// ---------------------------------------------------------------------------
// rv_exec_ctl -- execute-stage sequencer between decode, ALU and writeback.
//   clk, xreset                     : clock, asynchronous active-high reset
//   id_valid/id_ready               : op handshake from decode
//   id_alu, id_rd, id_rrd1/2, id_csr: op fields latched on accept
//   alu, rrd1, rrd2, csr_rd, rdy    : ALU drive (rdy = advance enable)
//   rwdat, cmpl, mulop              : ALU result, multi-cycle done, is mul/div
//   wb_valid/wb_ready, wb_rd/dat/err: writeback handshake (err = timeout)
//   kill                            : pipeline flush
//   stall_cnt                       : cumulative WAIT cycles
// ---------------------------------------------------------------------------
module rv_exec_ctl
    import pkg_rv_decode::*;
#(
    parameter int TIMEOUT = EX_TIMEOUT
) (
    input  logic     clk,
    input  logic     xreset,
    input  logic     id_valid,
    output logic     id_ready,
    input  alu_t     id_alu,
    input  reg_idx_t id_rd,
    input  u32_t     id_rrd1,
    input  u32_t     id_rrd2,
    input  u32_t     id_csr,
    output alu_t     alu,
    output u32_t     rrd1,
    output u32_t     rrd2,
    output u32_t     csr_rd,
    output logic     rdy,
    input  u32_t     rwdat,
    input  logic     cmpl,
    input  logic     mulop,
    output logic     wb_valid,
    input  logic     wb_ready,
    output reg_idx_t wb_rd,
    output u32_t     wb_dat,
    output logic     wb_err,
    input  logic     kill,
    output u32_t     stall_cnt
);

    ex_state_t state, state_nxt;

    alu_t     alu_q;
    reg_idx_t rd_q;
    u32_t     rrd1_q, rrd2_q, csr_q;

    logic accept;
    logic cap_res;   // capture ALU result as a normal completion
    logic cap_to;    // WAIT timed out: write back zero with error
    logic tmr_clr, tmr_en, tmr_term;

    assign accept = id_valid && id_ready;

    rv_ex_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .xreset (xreset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .term   (tmr_term)
    );

    // ---------------- state register ----------------
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge xreset) begin
        if (xreset)
            state <= EX_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // kill is tested first in every state so it wins over cmpl, wb_ready
    // and id_valid arriving in the same cycle.
    // NOTE: every output of a combinational block gets a default before the
    // case; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        cap_res   = 1'b0;
        cap_to    = 1'b0;
        case (state)
            EX_IDLE: begin
                if (accept)
                    state_nxt = EX_ISSUE;
            end
            EX_ISSUE: begin
                if (kill)
                    state_nxt = mulop ? EX_DRAIN : EX_IDLE;
                else if (!mulop || cmpl) begin
                    state_nxt = EX_DONE;
                    cap_res   = 1'b1;
                end else
                    state_nxt = EX_WAIT;
            end
            EX_WAIT: begin
                if (kill)
                    state_nxt = EX_DRAIN;
                else if (cmpl) begin
                    state_nxt = EX_DONE;
                    cap_res   = 1'b1;
                end else if (tmr_term) begin
                    state_nxt = EX_DONE;
                    cap_to    = 1'b1;
                end
            end
            EX_DONE: begin
                if (kill || wb_ready)
                    state_nxt = EX_IDLE;
            end
            EX_DRAIN: begin
                // The in-flight mul/div result is thrown away.
                if (cmpl || tmr_term)
                    state_nxt = EX_IDLE;
            end
            default: state_nxt = EX_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        id_ready = 1'b0;
        rdy      = 1'b0;
        wb_valid = 1'b0;
        alu      = ALU_ADD;   // harmless op so no mul/div is started
        tmr_en   = 1'b0;
        case (state)
            // Gated by xreset so id_ready stays low while reset is held.
            EX_IDLE:  id_ready = !kill && !xreset;
            EX_ISSUE: begin rdy = 1'b1; alu = alu_q; end
            EX_WAIT:  begin rdy = 1'b1; alu = alu_q; tmr_en = 1'b1; end
            EX_DONE:  wb_valid = 1'b1;
            EX_DRAIN: begin rdy = 1'b1; alu = alu_q; tmr_en = 1'b1; end
            default:  ;
        endcase
        // Restart the timer on each entry into a timed state, including
        // WAIT -> DRAIN so the drain gets its own full budget.
        tmr_clr = ((state_nxt == EX_WAIT) || (state_nxt == EX_DRAIN))
                  && (state_nxt != state);
    end

    assign rrd1   = rrd1_q;
    assign rrd2   = rrd2_q;
    assign csr_rd = csr_q;
    assign wb_rd  = rd_q;

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk or posedge xreset) begin
        if (xreset) begin
            alu_q     <= ALU_ADD;
            rd_q      <= '0;
            rrd1_q    <= '0;
            rrd2_q    <= '0;
            csr_q     <= '0;
            wb_dat    <= '0;
            wb_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                alu_q  <= id_alu;
                rd_q   <= id_rd;
                rrd1_q <= id_rrd1;
                rrd2_q <= id_rrd2;
                csr_q  <= id_csr;
                wb_err <= 1'b0;
            end
            if (cap_res) begin
                // x0 is hard-wired to zero.
                wb_dat <= (rd_q == '0) ? '0 : rwdat;
                wb_err <= 1'b0;
            end else if (cap_to) begin
                wb_dat <= '0;
                wb_err <= 1'b1;
            end
            // Counts WAIT cycles including one that is killed; wraps at 2^32.
            if (state == EX_WAIT)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_rv_exec_ctl.sv
// ---------------------------------------------------------------------------
// tb_rv_exec_ctl -- randomized scoreboard bench for rv_exec_ctl.
// The driver plays decode, ALU and writeback consumer; expected writebacks
// are queued when an op is issued and a separate monitor pops them when the
// DUT completes a writeback handshake.
// ---------------------------------------------------------------------------
module tb_rv_exec_ctl;
    import pkg_rv_decode::*;

    localparam int T = 64;

    typedef enum int {K_NONE, K_ISSUE, K_WAIT, K_DONE} kind_t;
    typedef struct {
        logic [4:0] rd;
        u32_t       dat;
        logic       err;
    } wb_exp_t;

    logic       clk = 1'b0;
    logic       xreset;
    logic       id_valid, id_ready;
    alu_t       id_alu, alu;
    logic [4:0] id_rd, wb_rd;
    u32_t       id_rrd1, id_rrd2, id_csr, rrd1, rrd2, csr_rd, rwdat, wb_dat, stall_cnt;
    logic       rdy, cmpl, mulop, wb_valid, wb_ready, wb_err, kill;

    int n_cmp = 0;
    int n_err = 0;
    u32_t stall_model = '0;
    wb_exp_t exp_q[$];

    rv_exec_ctl #(.TIMEOUT(T)) dut (
        .clk(clk), .xreset(xreset),
        .id_valid(id_valid), .id_ready(id_ready), .id_alu(id_alu), .id_rd(id_rd),
        .id_rrd1(id_rrd1), .id_rrd2(id_rrd2), .id_csr(id_csr),
        .alu(alu), .rrd1(rrd1), .rrd2(rrd2), .csr_rd(csr_rd), .rdy(rdy),
        .rwdat(rwdat), .cmpl(cmpl), .mulop(mulop),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_dat(wb_dat),
        .wb_err(wb_err), .kill(kill), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_md(alu_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Behavioural ALU: what the execute unit would return for an op.
    function automatic u32_t alu_fn(alu_t op, u32_t a, u32_t b);
        logic signed [63:0] p;
        bit ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return u32_t'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_MUL:  return a * b;
            ALU_MULH: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : u32_t'($signed(a) / $signed(b));
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:  return (b == 0) ? a : ovf ? 32'd0 : u32_t'($signed(a) % $signed(b));
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    // Cycle at which a drain ends (kill at kill_c, cmpl pulse at cmpl_c).
    function automatic int drain_end(int kill_c, int cmpl_c);
        if (cmpl_c > kill_c && cmpl_c <= kill_c + T) return cmpl_c;
        return kill_c + T;
    endfunction

    // ------------------------------------------------------------------
    // Driver for one op. Cycle c counts clock periods after the accept edge.
    // lat: -1 = cmpl never; 0 = cmpl during ISSUE; n = cmpl in n-th WAIT cycle.
    // d: number of wb_valid cycles held with wb_ready=0.
    // ------------------------------------------------------------------
    task automatic run_op(input alu_t op, input u32_t a, input u32_t b, input u32_t csr,
                          input logic [4:0] rd, input int lat, input int d,
                          input kind_t kk, input int kpos);
        bit md, to, exp_wb, fin;
        int done_c, idle_c, kill_c, cmpl_c, add_stall, first_v, exp_first, c, vcount;
        wb_exp_t e;
        md     = is_md(op);
        to     = md && (lat < 0);
        kill_c = -1;
        cmpl_c = (md && lat >= 0) ? 1 + lat : -1;
        if (!md)      begin done_c = 2;       add_stall = 0;   end
        else if (!to) begin done_c = 2 + lat; add_stall = lat; end
        else          begin done_c = 2 + T;   add_stall = T;   end
        exp_wb = 1'b1;
        idle_c = done_c + d + 1;
        case (kk)
            K_ISSUE: begin
                kill_c = 1; exp_wb = 1'b0; add_stall = 0;
                idle_c = md ? drain_end(kill_c, cmpl_c) + 1 : 2;
            end
            K_WAIT: begin
                kill_c = 1 + kpos; exp_wb = 1'b0; add_stall = kpos;
                idle_c = drain_end(kill_c, cmpl_c) + 1;
            end
            K_DONE: begin
                kill_c = done_c + kpos; exp_wb = 1'b0;
                idle_c = kill_c + 1;
            end
            default: ;
        endcase
        exp_first = (exp_wb || kk == K_DONE) ? done_c : -1;
        e.rd  = rd;
        e.err = to;
        e.dat = (to || rd == 5'd0) ? 32'd0 : alu_fn(op, a, b);
        if (exp_wb) exp_q.push_back(e);

        @(posedge clk); #1;
        id_valid = 1'b1; id_alu = op; id_rd = rd;
        id_rrd1 = a; id_rrd2 = b; id_csr = csr;
        kill = 1'b0; cmpl = 1'b0; wb_ready = (d == 0);
        @(negedge clk);
        check("id_ready_idle", id_ready, 1);

        c = 0; vcount = 0; first_v = -1; fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            c++;
            id_valid = 1'b0;
            kill     = (c == kill_c);
            cmpl     = (c == cmpl_c);
            wb_ready = (vcount >= d);
            mulop    = is_md(alu);
            rwdat    = alu_fn(alu, rrd1, rrd2);
            @(negedge clk);
            if (c == 1) begin
                check("issue_alu", alu, op);
                check("issue_rrd1", rrd1, a);
                check("issue_rrd2", rrd2, b);
                check("issue_csr", csr_rd, csr);
                check("issue_rdy", rdy, 1);
            end
            if (wb_valid) begin
                if (first_v < 0) begin
                    first_v = c;
                    check("done_alu", alu, ALU_ADD);
                    check("done_rdy", rdy, 0);
                end
                vcount++;
            end
            if (id_ready) fin = 1'b1;
            else if (c > idle_c + 20) begin
                check("op_stuck", c, idle_c);
                fin = 1'b1;
            end
        end
        kill = 1'b0; cmpl = 1'b0; mulop = 1'b0;
        check("idle_cycle", c, idle_c);
        check("first_valid_cycle", first_v, exp_first);
        stall_model += add_stall;
        check("stall_cnt", stall_cnt, stall_model);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_id_ready"}, id_ready, 0);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_wb_rd"}, wb_rd, 0);
        check({tag, "_wb_dat"}, wb_dat, 0);
        check({tag, "_wb_err"}, wb_err, 0);
        check({tag, "_stall"}, stall_cnt, 0);
        check({tag, "_alu"}, alu, ALU_ADD);
        check({tag, "_rrd1"}, rrd1, 0);
        check({tag, "_rrd2"}, rrd2, 0);
        check({tag, "_csr"}, csr_rd, 0);
        check({tag, "_rdy"}, rdy, 0);
    endtask

    // Reset asserted while a MUL sits in WAIT: the op must vanish.
    task automatic reset_in_wait();
        @(posedge clk); #1;
        id_valid = 1'b1; id_alu = ALU_MUL; id_rd = 5'd7;
        id_rrd1 = 32'd3; id_rrd2 = 32'd4; id_csr = 32'h55; wb_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            id_valid = 1'b0; cmpl = 1'b0;
            mulop = is_md(alu); rwdat = alu_fn(alu, rrd1, rrd2);
        end
        @(negedge clk);
        check("pre_reset_rdy", rdy, 1);
        #2 xreset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        @(posedge clk); #1;
        xreset = 1'b0; mulop = 1'b0;
        stall_model = '0;
        @(negedge clk);
        check("post_reset_id_ready", id_ready, 1);
        check("post_reset_wb_valid", wb_valid, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic       held_v = 1'b0;
    logic [4:0] h_rd;
    u32_t       h_dat;
    logic       h_err;

    always @(negedge clk) begin : monitor
        wb_exp_t m;
        if (xreset) held_v = 1'b0;
        else if (wb_valid) begin
            check("id_ready_in_done", id_ready, 0);
            if (held_v) begin
                check("hold_wb_rd", wb_rd, h_rd);
                check("hold_wb_dat", wb_dat, h_dat);
                check("hold_wb_err", wb_err, h_err);
            end
            if (wb_ready && !kill) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wb_unexpected: rd=%0d dat=0x%08h with nothing expected", wb_rd, wb_dat);
                end else begin
                    m = exp_q.pop_front();
                    check("wb_rd", wb_rd, m.rd);
                    check("wb_dat", wb_dat, m.dat);
                    check("wb_err", wb_err, m.err);
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1; h_rd = wb_rd; h_dat = wb_dat; h_err = wb_err;
            end
        end else held_v = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        xreset = 1'b1; id_valid = 1'b0; id_alu = ALU_ADD; id_rd = '0;
        id_rrd1 = '0; id_rrd2 = '0; id_csr = '0; rwdat = '0;
        cmpl = 1'b0; mulop = 1'b0; wb_ready = 1'b0; kill = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 xreset = 1'b0;
        @(negedge clk);
        check("release_id_ready", id_ready, 1);

        // ADD 5+7 -> x3, immediate consumer
        run_op(ALU_ADD, 32'd5, 32'd7, 32'h1, 5'd3, 0, 0, K_NONE, 0);
        // DIV 20/5, cmpl in 33rd WAIT cycle
        run_op(ALU_DIV, 32'd20, 32'd5, 32'h2, 5'd5, 33, 0, K_NONE, 0);
        // Writeback back-pressure for 10 cycles
        run_op(ALU_SUB, 32'd100, 32'd1, 32'h3, 5'd9, 0, 10, K_NONE, 0);
        // MUL that never completes -> timeout error
        run_op(ALU_MUL, 32'd6, 32'd7, 32'h4, 5'd11, -1, 0, K_NONE, 0);
        // kill in 3rd WAIT cycle, cmpl 5 cycles later
        run_op(ALU_MULH, 32'd6, 32'd7, 32'h5, 5'd12, 8, 0, K_WAIT, 3);
        // write to x0 is forced to zero
        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd0, 32'h6, 5'd0, 0, 0, K_NONE, 0);
        // kill in ISSUE (single-cycle) and in DONE
        run_op(ALU_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h7, 5'd13, 0, 0, K_ISSUE, 0);
        run_op(ALU_OR, 32'h1234_0000, 32'h0000_5678, 32'h8, 5'd14, 0, 3, K_DONE, 1);
        // mul/div completing during ISSUE
        run_op(ALU_REMU, 32'd17, 32'd5, 32'h9, 5'd15, 0, 1, K_NONE, 0);
        // mul/div killed in WAIT with no cmpl: drain times out
        run_op(ALU_DIVU, 32'd99, 32'd3, 32'hA, 5'd16, -1, 0, K_WAIT, 2);

        // kill in IDLE blocks acceptance
        @(posedge clk); #1;
        id_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        check("kill_idle_id_ready", id_ready, 0);
        @(posedge clk); #1;
        id_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_idle_no_accept", id_ready, 1);

        for (int i = 0; i < 40; i++) begin
            automatic alu_t       op  = alu_t'($urandom_range(0, 15));
            automatic u32_t       a   = $urandom;
            automatic u32_t       b   = $urandom;
            automatic u32_t       csr = $urandom;
            automatic logic [4:0] rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            automatic int         lat = 0;
            automatic int         d   = $urandom_range(0, 3);
            automatic int         kp  = 0;
            automatic int         sel = $urandom_range(0, 9);
            automatic int         r   = $urandom_range(0, 7);
            automatic kind_t      kk  = K_NONE;
            if (is_md(op))
                lat = (r == 0) ? -1 : (r == 1) ? 0 : $urandom_range(2, 40);
            if (sel == 0)
                kk = K_ISSUE;
            else if (sel == 1 && is_md(op) && lat != 0) begin
                kk = K_WAIT;
                kp = $urandom_range(1, (lat < 0) ? 20 : lat - 1);
            end else if (sel == 2) begin
                kk = K_DONE;
                if (d == 0) d = 1;
                kp = $urandom_range(0, d - 1);
            end
            run_op(op, a, b, csr, rd, lat, d, kk, kp);
        end

        reset_in_wait();
        run_op(ALU_SLT, 32'hFFFF_FFFE, 32'd1, 32'hB, 5'd20, 0, 0, K_NONE, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_exec_ctl.md
RV_EXEC_CTL -- requirements
Module: rv_exec_ctl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the maximum number of WAIT/DRAIN cycles allowed before abort.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; xreset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: id_valid  in  1  decode offers an op; id_ready  out  1  controller accepts; id_alu  in  alu_t  operation; id_rd  in  5  destination index; id_rrd1, id_rrd2  in  32 each  operands; id_csr  in  32  CSR read value.
REQ-004 SHALL have ports: alu  out  alu_t;  rrd1, rrd2, csr_rd  out  32 each;  rdy  out  1  ALU advance enable;  rwdat  in  32  ALU result;  cmpl  in  1  multi-cycle completion pulse;  mulop  in  1  current op is mul/div.
REQ-005 SHALL have ports: wb_valid  out  1;  wb_ready  in  1;  wb_rd  out  5;  wb_dat  out  32;  wb_err  out  1  timeout flag;  kill  in  1  flush;  stall_cnt  out  32  cumulative WAIT cycles.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-007 id_ready SHALL be 1 only in IDLE with kill=0; a handshake (id_valid & id_ready) latches alu/rd/operands/csr into registers and moves to ISSUE.
REQ-008 alu, rrd1, rrd2, csr_rd SHALL be driven from the latched registers; in IDLE and DONE alu SHALL be ADD so no mul/div is started.
REQ-009 In ISSUE with mulop=0, rwdat SHALL be captured into wb_dat and the state SHALL move to DONE (accept edge k -> wb_valid=1 from cycle k+2).
REQ-010 In ISSUE with mulop=1, the state SHALL move to WAIT; in WAIT, cmpl=1 SHALL capture rwdat and move to DONE.
REQ-011 A cmpl arriving while in ISSUE with mulop=1 SHALL be treated as completion (ISSUE -> DONE).
REQ-012 rdy SHALL be 1 in ISSUE, WAIT and DRAIN, and 0 otherwise.
REQ-013 wb_valid SHALL equal (state==DONE); wb_rd/wb_dat/wb_err SHALL stay stable while wb_valid=1 and wb_ready=0; wb_valid & wb_ready SHALL move DONE -> IDLE.
REQ-014 If the latched rd is 0, wb_dat SHALL be 0 regardless of rwdat.
REQ-015 A counter SHALL clear on entry to WAIT/DRAIN and increment each cycle there; reaching TIMEOUT in WAIT SHALL move to DONE with wb_dat=0 and wb_err=1; reaching it in DRAIN SHALL move to IDLE.
REQ-016 wb_err SHALL be 0 for every normally completed op.
REQ-017 kill in IDLE, ISSUE(mulop=0) or DONE SHALL force IDLE next cycle, drop wb_valid and discard the op; kill in ISSUE(mulop=1) or WAIT SHALL move to DRAIN.
REQ-018 DRAIN SHALL hold id_ready=0 and move to IDLE on cmpl or timeout, discarding rwdat; kill in DRAIN has no further effect.
REQ-019 kill SHALL take priority over cmpl, wb_ready and id_valid in the same cycle.
REQ-020 stall_cnt SHALL increment once per WAIT cycle, wrap modulo 2^32, and be unaffected by kill.

Reset
REQ-021 While xreset=1 the block SHALL be in IDLE with id_ready=0, wb_valid=0, wb_rd=0, wb_dat=0, wb_err=0, stall_cnt=0, alu=ADD, rrd1=rrd2=csr_rd=0, rdy=0 and the timeout counter 0.
REQ-022 Reset asserted mid-operation (WAIT/DRAIN) SHALL abandon the op with no wb_valid pulse; id_ready SHALL rise in the first cycle after release.

Structure
REQ-023 u32_t SHALL come from rv_types.svh and alu_t from pkg_rv_decode; the state enum ex_state_t and the TIMEOUT default SHALL be added to pkg_rv_decode.
REQ-024 The timeout counter (clear, enable, terminal flag) SHALL be the single sub-module rv_ex_timer; there SHALL be no other sub-modules.

Verification
REQ-025 ADD with rrd1=5, rrd2=7, rd=3, wb_ready=1 -> wb_valid exactly 2 cycles after accept, wb_rd=3, wb_dat=12, wb_err=0, stall_cnt unchanged.
REQ-026 DIV with mulop=1 and cmpl at the 33rd WAIT cycle, rwdat=0x00000004 -> wb_dat=4, stall_cnt +33, id_ready low throughout.
REQ-027 wb_ready held 0 for 10 cycles after wb_valid -> wb_dat stable and id_ready=0 for those 10 cycles, IDLE one cycle after wb_ready=1.
REQ-028 MUL with cmpl never asserted, TIMEOUT=64 -> wb_valid with wb_err=1, wb_dat=0 after 64 WAIT cycles.
REQ-029 kill in the 3rd WAIT cycle, cmpl 5 cycles later -> no wb_valid, id_ready=1 the cycle after the cmpl.
REQ-030 ADD with rd=0, rwdat=0xFFFFFFFF -> wb_dat=0; xreset pulse during WAIT -> all outputs at reset values, no wb_valid.
